// File: rtl/rambam_pkg.sv
// Shared types for the masked-AES multiplier scheduler.
// Operand width is 8+D bits, MSB at index 0.
package rambam_pkg;

  localparam int unsigned D = 8;

  typedef logic [0:7+D] op_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request
// at or after ptr_i, wrapping modulo N.
module rr_arbiter
  import rambam_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  localparam logic [IW:0] NV = (IW+1)'(N);

  logic [IW:0]   sum;
  logic [IW-1:0] pos;
  logic          hit;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    hit   = 1'b0;
    sum   = '0;
    pos   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sum = {1'b0, ptr_i} + (IW+1)'(i);
      if (sum >= NV) sum = sum - NV;
      pos = sum[IW-1:0];
      if (!hit && req_i[pos]) begin
        hit        = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = pos;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/mult_rr_sched.sv
// Round-robin scheduler sharing one serial multiplier
// among N requesters, with a WAIT watchdog.
module mult_rr_sched
  import rambam_pkg::*;
#(
  parameter int unsigned d       = D,
  parameter int unsigned N       = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req_i,
  input  logic [N-1:0][0:7+d] a_i,
  input  logic [N-1:0][0:7+d] b_i,
  output logic [N-1:0]        gnt_o,
  output logic [N-1:0]        done_o,
  output logic [0:7+d]        res_o,
  output logic                busy_o,
  output logic                err_o,
  output logic                mult_drdy_i,
  output logic [0:7+d]        mult_p1,
  output logic [0:7+d]        mult_p2,
  input  logic                mult_drdy_o,
  input  logic [0:7+d]        mult_out
);

  localparam int unsigned IW  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned WDW = $clog2(TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);
  localparam logic [IW-1:0]  IDX_LAST = IW'(N - 1);

  sched_state_e   state_q, state_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic [IW-1:0]  owner_q, owner_d;
  logic [0:7+d]   op1_q, op1_d;
  logic [0:7+d]   op2_q, op2_d;
  logic [0:7+d]   res_q, res_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [N-1:0]   done_q, done_d;
  logic           err_q, err_d;
  logic [WDW-1:0] wdog_q, wdog_d;

  logic [N-1:0]   arb_gnt;
  logic [IW-1:0]  arb_idx;
  logic           arb_any;

  rr_arbiter #(
    .N (N)
  ) u_arb (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    res_d   = res_q;
    err_d   = err_q;
    wdog_d  = wdog_q;
    gnt_d   = '0;
    done_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          op1_d   = a_i[arb_idx];
          op2_d   = b_i[arb_idx];
          owner_d = arb_idx;
          gnt_d   = arb_gnt;
          ptr_d   = (arb_idx == IDX_LAST) ? '0 : arb_idx + IW'(1);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wdog_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A result arriving on the watchdog's last cycle still wins.
        if (mult_drdy_o) begin
          res_d           = mult_out;
          done_d[owner_q] = 1'b1;
          state_d         = IDLE;
        end else if (wdog_q == WD_LAST) begin
          err_d           = 1'b1;
          res_d           = '0;
          done_d[owner_q] = 1'b1;
          state_d         = IDLE;
        end else begin
          wdog_d = wdog_q + WDW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      res_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      res_q   <= res_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      wdog_q  <= wdog_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign done_o      = done_q;
  assign res_o       = res_q;
  assign busy_o      = (state_q != IDLE);
  assign err_o       = err_q;
  assign mult_drdy_i = (state_q == ISSUE);
  assign mult_p1     = op1_q;
  assign mult_p2     = op2_q;

endmodule
